nes_button_event_queue: RTL and testbench
=========================================

Name: nes_button_event_queue

Overview:
- Downstream consumer of the NES controller shift-register stage.
- Samples the 8-bit button snapshot once per read frame and debounces it across consecutive frames.
- Converts committed state changes into press/release events, one per button, and queues them in a small first-word-fall-through FIFO with a valid/ready read port for game/UI logic.

Parameters:
- STABLE_COUNT, 2: consecutive identical frames required before a new button state commits (1..15).
- FIFO_DEPTH, 8: event queue depth; power of two, at least 2.
- ACTIVE_LOW, 1: when 1, a snapshot bit of 0 means pressed (raw NES data line polarity).

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-high reset.
- pressedButtons, input, 8: snapshot from the shift-register stage; bit7 = A, bit6 = B, bit5 = Select, bit4 = Start, bit3 = Up, bit2 = Down, bit1 = Left, bit0 = Right.
- fullReg, input, 1: frame-complete flag from the shift-register stage; changes on negedge, so it is stable at posedge.
- evt_valid, output, 1: FIFO non-empty.
- evt_ready, input, 1: consumer accepts the head event.
- evt_data, output, 4: head event {press, idx[2:0]}; press = 1 for press, 0 for release; idx = bit position.
- buttons_stable, output, 8: committed debounced state, active-high (1 = pressed).
- fifo_count, output, clog2(FIFO_DEPTH)+1: occupancy.
- overflow, output, 1: sticky; set when an event is dropped.

Behaviour:
- Reset, asynchronous, any time including mid-emission, forces:
  - buttons_stable, the candidate register, the debounce counter, the pending mask, FIFO pointers, fifo_count and overflow to 0.
  - evt_valid = 0, evt_data = 0.
- Frame strobe: asserted on a posedge where fullReg = 1 and the registered previous fullReg = 0. A fullReg held high for several cycles yields exactly one strobe.
- Normalise: raw = ACTIVE_LOW ? ~pressedButtons : pressedButtons, captured only at a strobe.
- Debounce, at each strobe:
  - If raw == candidate: the counter increments, saturating at STABLE_COUNT.
  - Otherwise: candidate <= raw and counter <= 1.
  - STABLE_COUNT = 1 means the first frame commits.
- Commit condition, evaluated at that same strobe edge using the updated counter: counter == STABLE_COUNT, candidate != buttons_stable, and pending == 0.
  - On commit: pending <= candidate ^ buttons_stable and buttons_stable <= candidate.
  - If pending != 0, the commit is deferred. The candidate keeps being compared, and the commit occurs at the first later strobe with pending == 0 and the condition still true.
- Emitter state machine:
  - IDLE while pending == 0; EMIT otherwise.
  - In EMIT, each cycle selects the highest set bit i of pending and clears it.
  - It generates event {buttons_stable[i], i} and pushes it.
  - One event per cycle. First push occurs on the edge after the commit edge, so evt_valid rises 1 cycle after commit.
  - Returns to IDLE when pending becomes 0.
- FIFO rules:
  - First-word fall-through: evt_data shows the head whenever evt_valid = 1, and is held at the last value/don't-care when empty.
  - Pop occurs when evt_valid & evt_ready.
  - Push when full is accepted only if a pop occurs in the same cycle; otherwise the event is dropped and overflow <= 1.
  - Push and pop together when empty: the push succeeds and the pop is ignored (evt_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.
- Changes to evt_ready or pressedButtons between strobes have no effect on the debounce state.

Test Plan:
- Reset mid-EMIT with 3 events queued -> next cycle evt_valid = 0, fifo_count = 0, buttons_stable = 0x00, overflow = 0; after release, idle 0xFF frames produce no events.
- pressedButtons = 0x7F for 2 strobes, evt_ready = 1 -> buttons_stable = 0x80 at the 2nd strobe; a single event evt_data = 0xF, with evt_valid high 1 cycle after commit.
- Glitch: 0xFF, one strobe at 0x7F, then 0xFF strobes -> no event, buttons_stable stays 0x00.
- From stable 0x80, apply 0x7E ×2 -> event 0x8; then 0xFF ×2 -> events 0x7 then 0x0 in that order; final buttons_stable = 0x00.
- Backpressure: evt_ready = 0, press all (0x00 ×2) then release all (0xFF ×2) -> fifo_count = 8, overflow = 1 after the 9th event. Draining yields 0xF, 0xE, 0xD, 0xC, 0xB, 0xA, 0x9, 0x8, and overflow stays 1.
- FIFO full with evt_ready = 1 during a push cycle -> push accepted, fifo_count stays 8, overflow unchanged; fullReg held high 3 cycles -> only one debounce step.

Source files
------------

// File: rtl/nes_button_event_queue.sv
// Debounces NES controller snapshots frame by frame and turns committed button
// changes into press/release events, queued in a small first-word-fall-through FIFO.
module nes_button_event_queue #(
  parameter int STABLE_COUNT = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    pressedButtons,
  input  logic                          fullReg,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [3:0]                    evt_data,
  output logic [7:0]                    buttons_stable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]  STABLE_N = 4'(STABLE_COUNT);
  localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_reg;
  logic          full_prev_reg;
  logic [7:0]    cand_reg, cand_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [7:0]    stable_reg;
  logic [7:0]    pending_reg, pending_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [3:0]    mem [FIFO_DEPTH];

  logic          strobe;
  logic [7:0]    raw;
  logic          commit;
  logic [2:0]    hi_idx;
  logic [3:0]    emit_evt;
  logic          push, pop, push_ok, fifo_full;

  // A frame-complete flag held high for several cycles counts as one frame.
  assign strobe = fullReg & ~full_prev_reg;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_norm
      assign raw[gi] = (ACTIVE_LOW != 0) ? ~pressedButtons[gi] : pressedButtons[gi];
    end
  endgenerate

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    if (strobe) begin
      if (raw == cand_reg) begin
        cnt_next = (cnt_reg >= STABLE_N) ? cnt_reg : cnt_reg + 4'd1;
      end else begin
        cand_next = raw;
        cnt_next  = 4'd1;
      end
    end
  end

  // A commit waits until every event of the previous commit has been emitted.
  assign commit = strobe && (cnt_next == STABLE_N) && (cand_next != stable_reg)
                  && (pending_reg == 8'd0);

  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_reg[i]) hi_idx = 3'(i);
    end
  end

  assign emit_evt = {stable_reg[hi_idx], hi_idx};

  always_comb begin
    pending_next = pending_reg;
    if (commit)
      pending_next = cand_next ^ stable_reg;
    else if (state_reg == EMIT)
      pending_next = pending_reg & ~(8'd1 << hi_idx);
  end

  assign push      = (state_reg == EMIT);
  assign fifo_full = (count_reg == DEPTH_N);
  assign pop       = evt_valid & evt_ready;
  // A full queue only takes a new event if the head leaves in the same cycle.
  assign push_ok   = push & (~fifo_full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      full_prev_reg <= 1'b0;
      cand_reg      <= 8'd0;
      cnt_reg       <= 4'd0;
      stable_reg    <= 8'd0;
      pending_reg   <= 8'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      full_prev_reg <= fullReg;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      state_reg     <= (pending_next != 8'd0) ? EMIT : IDLE;
      if (commit) stable_reg <= cand_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (push & ~push_ok) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= emit_evt;
  end

  assign evt_valid      = (count_reg != '0);
  assign evt_data       = evt_valid ? mem[rd_ptr_reg] : 4'd0;
  assign buttons_stable = stable_reg;
  assign fifo_count     = count_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_nes_button_event_queue.sv
// Directed bench for nes_button_event_queue: expected events are queued when a
// commit is driven and compared as the consumer accepts them.
module tb_nes_button_event_queue;

  logic       clk;
  logic       reset;
  logic [7:0] pressedButtons;
  logic       fullReg;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;
  logic [7:0] buttons_stable;
  logic [3:0] fifo_count;
  logic       overflow;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];

  nes_button_event_queue #(.STABLE_COUNT(2), .FIFO_DEPTH(8), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset(reset),
    .pressedButtons(pressedButtons),
    .fullReg(fullReg),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .buttons_stable(buttons_stable),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are stable at the negedge and evt_ready is already set for the
  // coming posedge, so valid & ready here means the head pops on that edge.
  task automatic tick();
    logic [3:0] e;
    if (evt_valid && evt_ready) begin
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_evt: observed %h expected none", evt_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("evt_data", {4'h0, evt_data}, {4'h0, e});
        $display("event %h accepted, expected %h", evt_data, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe_hi(input logic [7:0] v);
    pressedButtons = v;
    fullReg = 1'b1;
    tick();
  endtask

  task automatic strobe_lo();
    fullReg = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [7:0] v);
    strobe_hi(v);
    strobe_lo();
  endtask

  initial begin
    reset = 1'b1;
    pressedButtons = 8'hFF;
    fullReg = 1'b0;
    evt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {7'd0, evt_valid}, 8'd0);
    check("rst_data", {4'd0, evt_data}, 8'd0);
    check("rst_count", {4'd0, fifo_count}, 8'd0);
    check("rst_stable", buttons_stable, 8'h00);
    check("rst_overflow", {7'd0, overflow}, 8'd0);
    reset = 1'b0;
    tick();

    // Single-frame glitch never reaches the committed state.
    strobe(8'hFF);
    strobe(8'h7F);
    strobe(8'hFF);
    strobe(8'hFF);
    ticks(3);
    check("glitch_stable", buttons_stable, 8'h00);
    check("glitch_valid", {7'd0, evt_valid}, 8'd0);

    // Press A: commit on the 2nd strobe, event visible one cycle later.
    strobe(8'h7F);
    check("a_stable_pre", buttons_stable, 8'h00);
    exp_q.push_back(4'hF);
    strobe_hi(8'h7F);
    check("a_stable", buttons_stable, 8'h80);
    check("a_valid_commit", {7'd0, evt_valid}, 8'd0);
    strobe_lo();
    check("a_valid_next", {7'd0, evt_valid}, 8'd1);
    ticks(4);

    // Add Right, then release both: highest index emitted first.
    strobe(8'h7E);
    exp_q.push_back(4'h8);
    strobe(8'h7E);
    check("ar_stable", buttons_stable, 8'h81);
    ticks(4);
    strobe(8'hFF);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h0);
    strobe(8'hFF);
    ticks(5);
    check("rel_stable", buttons_stable, 8'h00);

    // fullReg held high for 3 cycles is a single frame.
    pressedButtons = 8'h7F;
    fullReg = 1'b1;
    ticks(3);
    fullReg = 1'b0;
    tick();
    check("held_stable", buttons_stable, 8'h00);
    exp_q.push_back(4'hF);
    strobe(8'h7F);
    check("held_commit", buttons_stable, 8'h80);
    strobe(8'hFF);
    exp_q.push_back(4'h7);
    strobe(8'hFF);
    ticks(5);

    // Backpressure: 8 presses fill the queue, 8 releases are dropped.
    evt_ready = 1'b0;
    strobe(8'h00);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, 3'(i)});
    strobe(8'h00);
    ticks(10);
    check("bp_count_full", {4'd0, fifo_count}, 8'd8);
    check("bp_ovf_before", {7'd0, overflow}, 8'd0);
    strobe(8'hFF);
    strobe(8'hFF);
    ticks(10);
    check("bp_count", {4'd0, fifo_count}, 8'd8);
    check("bp_overflow", {7'd0, overflow}, 8'd1);
    evt_ready = 1'b1;
    ticks(12);
    check("bp_drain_count", {4'd0, fifo_count}, 8'd0);
    check("bp_ovf_sticky", {7'd0, overflow}, 8'd1);
    check("bp_q_empty", 8'(exp_q.size()), 8'd0);

    // Reset while emitting with 3 events queued.
    evt_ready = 1'b0;
    strobe(8'h00);
    strobe_hi(8'h00);
    strobe_lo();
    ticks(2);
    check("mid_count", {4'd0, fifo_count}, 8'd3);
    reset = 1'b1;
    tick();
    check("mr_valid", {7'd0, evt_valid}, 8'd0);
    check("mr_count", {4'd0, fifo_count}, 8'd0);
    check("mr_stable", buttons_stable, 8'h00);
    check("mr_overflow", {7'd0, overflow}, 8'd0);
    reset = 1'b0;
    evt_ready = 1'b1;
    tick();
    strobe(8'hFF);
    strobe(8'hFF);
    strobe(8'hFF);
    ticks(5);
    check("idle_valid", {7'd0, evt_valid}, 8'd0);
    check("idle_count", {4'd0, fifo_count}, 8'd0);

    // Full queue with a pop in the same cycle accepts the push.
    evt_ready = 1'b0;
    strobe(8'h00);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, 3'(i)});
    strobe(8'h00);
    ticks(10);
    check("fp_count_full", {4'd0, fifo_count}, 8'd8);
    strobe(8'hFF);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, 3'(i)});
    strobe_hi(8'hFF);
    evt_ready = 1'b1;
    strobe_lo();
    check("fp_count_hold", {4'd0, fifo_count}, 8'd8);
    check("fp_ovf_hold", {7'd0, overflow}, 8'd0);
    ticks(20);
    check("fp_count_end", {4'd0, fifo_count}, 8'd0);
    check("fp_ovf_end", {7'd0, overflow}, 8'd0);
    check("fp_q_empty", 8'(exp_q.size()), 8'd0);
    check("fp_stable", buttons_stable, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
